// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
// Shared definitions for the instruction fetch stage and the decode
// controller that consumes its IF/ID register: fetch FSM encoding, the NOP
// word presented when the stage is empty, and instruction field positions.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // ADDI x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Field slice positions used by decode.
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_MSB = 6;
  localparam int unsigned F3_LSB     = 12;
  localparam int unsigned F3_MSB     = 14;
  localparam int unsigned F7_LSB     = 25;
  localparam int unsigned F7_MSB     = 31;

  // Sequential PC, wrapping modulo 2^32.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf
// One-entry holding buffer for a fetched {instr, pc} pair that arrives while
// decode is stalled and the IF/ID register is already occupied.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   clr              discard the entry (redirect); wins over push/pop
//   push             write push_instr/push_pc; may coincide with pop
//   pop              entry consumed by the IF/ID register
//   push_instr/_pc   incoming entry
//   valid, instr, pc stored entry
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_instr,
  input  logic [XLEN-1:0] push_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // Next-state of the single entry.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (push) begin
      valid_d = 1'b1;
      instr_d = push_instr;
      pc_d    = push_pc;
    end else if (pop) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0000_0000;
      pc_q    <= 32'h0000_0000;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch stage with IF/ID pipeline register. Owns the PC, issues
// single-outstanding requests to instruction memory, and presents a
// registered instruction with its PC, PC+4 and pre-sliced decode fields.
// Decode stalls are absorbed by a one-entry skid buffer; redirects squash
// any in-flight response.
// Optional feature (macro FETCH_MISALIGN_CHECK_EN): misaligned redirect
// targets are reported on id_misalign instead of being fetched.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   imem_req/addr               fetch request and address (addr = pc_q)
//   imem_gnt                    request accepted
//   imem_rvalid/rdata           response
//   id_stall                    decode cannot accept; id_* hold
//   redirect_valid/pc           taken branch / jump target
//   id_valid/instr/pc/pc4       IF/ID register contents
//   id_opcode/f3/f7             instruction fields for the controller
//   id_misalign                 (optional) misaligned redirect target
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_f3,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic [6:0]  id_f7,
  output logic        id_misalign
`else
  output logic [6:0]  id_f7
`endif
);

  import fetch_stage_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_resp_q, pc_resp_d;
  logic         id_valid_q, id_valid_d;
  logic [31:0]  id_instr_q, id_instr_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic [31:0]  id_pc4_q, id_pc4_d;
  logic         misalign_q, misalign_d;

  logic         req_s;
  logic [31:0]  redirect_tgt_s;
  logic         redirect_misal_s;
  logic         take_resp_s;
  logic         id_free_s;
  logic         skid_clr_s, skid_push_s, skid_pop_s;
  logic         skid_valid_s;
  logic [31:0]  skid_instr_s, skid_pc_s;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_tgt_s   = redirect_pc;
  assign redirect_misal_s = |redirect_pc[1:0];
`else
  assign redirect_tgt_s   = redirect_pc & 32'hFFFF_FFFC;
  assign redirect_misal_s = 1'b0;
`endif

  // Only WAIT responses are real; DRAIN responses belong to squashed fetches.
  assign take_resp_s = (state_q == WAIT) && imem_rvalid;
  // IF/ID can be overwritten this cycle.
  assign id_free_s   = !id_valid_q || !id_stall;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .clr        (skid_clr_s),
    .push       (skid_push_s),
    .pop        (skid_pop_s),
    .push_instr (imem_rdata),
    .push_pc    (pc_resp_q),
    .valid      (skid_valid_s),
    .instr      (skid_instr_s),
    .pc         (skid_pc_s)
  );

  // Fetch FSM, PC update, request generation and IF/ID loading.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_resp_d   = pc_resp_q;
    id_valid_d  = id_valid_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    misalign_d  = misalign_q;
    req_s       = 1'b0;
    skid_clr_s  = 1'b0;
    skid_push_s = 1'b0;
    skid_pop_s  = 1'b0;

    if (redirect_valid) begin
      pc_d       = redirect_tgt_s;
      skid_clr_s = 1'b1;
      misalign_d = redirect_misal_s;
      if (redirect_misal_s) begin
        id_valid_d = 1'b1;
        id_instr_d = NOP_INSTR;
        id_pc_d    = redirect_tgt_s;
        id_pc4_d   = pc_plus4(redirect_tgt_s);
      end else begin
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
      end
      // A response landing this cycle retires the outstanding request, so
      // only a still-pending one needs draining. No request is driven while
      // redirecting, so a FETCH-state grant cannot create an outstanding one.
      if (((state_q == WAIT) || (state_q == DRAIN)) && !imem_rvalid) begin
        state_d = DRAIN;
      end else begin
        state_d = FETCH;
      end
    end else begin
      // IF/ID loading: skid entry first (it is older), then a new response.
      if (id_free_s) begin
        if (skid_valid_s) begin
          id_valid_d  = 1'b1;
          id_instr_d  = skid_instr_s;
          id_pc_d     = skid_pc_s;
          id_pc4_d    = pc_plus4(skid_pc_s);
          skid_pop_s  = 1'b1;
          skid_push_s = take_resp_s;
        end else if (take_resp_s) begin
          id_valid_d = 1'b1;
          id_instr_d = imem_rdata;
          id_pc_d    = pc_resp_q;
          id_pc4_d   = pc_plus4(pc_resp_q);
        end else if (!id_stall && !misalign_q) begin
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
        end else begin
          // Misaligned-target report stays presented until the next redirect.
          id_valid_d = id_valid_q;
        end
      end else begin
        skid_push_s = take_resp_s;
      end

      case (state_q)
        BOOT: begin
          state_d = FETCH;
        end
        FETCH: begin
          req_s = !skid_valid_s && !misalign_q;
          if (req_s && imem_gnt) begin
            pc_resp_d = pc_q;
            pc_d      = pc_plus4(pc_q);
            state_d   = WAIT;
          end else begin
            state_d = FETCH;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            // Issue back-to-back only when this response lands directly in
            // IF/ID, so the skid buffer stays free for the next response.
            req_s = !skid_valid_s && id_free_s;
            if (req_s && imem_gnt) begin
              pc_resp_d = pc_q;
              pc_d      = pc_plus4(pc_q);
              state_d   = WAIT;
            end else begin
              state_d = FETCH;
            end
          end else begin
            state_d = WAIT;
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            state_d = FETCH;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  // State and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pc_resp_q  <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= 32'h0000_0000;
      id_pc4_q   <= 32'h0000_0004;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_resp_q  <= pc_resp_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req  = req_s;
  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc4_q;
  assign id_opcode = id_instr_q[OPCODE_MSB:OPCODE_LSB];
  assign id_f3     = id_instr_q[F3_MSB:F3_LSB];
  assign id_f7     = id_instr_q[F7_MSB:F7_LSB];
`ifdef FETCH_MISALIGN_CHECK_EN
  assign id_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed + randomized bench for fetch_stage. A behavioural instruction
// memory answers granted requests after a chosen latency, and a scoreboard
// expects decode to see the program in order: consecutive words from the
// last redirect target (or 0 after reset), one per consumed cycle.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc4;
  logic [6:0]  id_opcode, id_f7;
  logic [2:0]  id_f3;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        id_misalign;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc4         (id_pc4),
    .id_opcode      (id_opcode),
    .id_f3          (id_f3),
`ifdef FETCH_MISALIGN_CHECK_EN
    .id_f7          (id_f7),
    .id_misalign    (id_misalign)
`else
    .id_f7          (id_f7)
`endif
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc_n = 0;
  int          consumed = 0;
  int          lat = 1;
  logic [31:0] exp_pc = 32'h0;
  // memory: at most one pending response
  logic        pend_v = 1'b0;
  int          pend_due = 0;
  logic [31:0] pend_data = 32'h0;
  // previous-cycle observations
  logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_redir = 1'b0;
  logic        prev_valid = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_instr = 32'h0, prev_pc = 32'h0, prev_pc4 = 32'h0;
  logic        last_req = 1'b0, last_rvalid = 1'b0;
  logic [31:0] last_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    else if (a == 32'h4) return 32'h0010_0113;
    else return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cyc(input logic gnt, input logic stall, input logic redir, input logic [31:0] rpc);
    logic [31:0] w;
    logic        misal;
`ifdef FETCH_MISALIGN_CHECK_EN
    misal = id_misalign;
`else
    misal = 1'b0;
`endif
    if (prev_valid && prev_stall && !prev_redir) begin
      chk("hold_valid", id_valid, 32'd1);
      chk("hold_instr", id_instr, prev_instr);
      chk("hold_pc", id_pc, prev_pc);
      chk("hold_pc4", id_pc4, prev_pc4);
    end
    imem_gnt       = gnt;
    id_stall       = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rvalid    = pend_v && (pend_due == cyc_n);
    imem_rdata     = imem_rvalid ? pend_data : $urandom;
    #1;
    last_req    = imem_req;
    last_addr   = imem_addr;
    last_rvalid = imem_rvalid;
    if (redir) begin
      chk("no_req_on_redirect", imem_req, 32'd0);
    end else if (prev_req && !prev_gnt) begin
      chk("req_held", imem_req, 32'd1);
      chk("addr_stable", imem_addr, prev_addr);
    end
    if (imem_rvalid) pend_v = 1'b0;
    if (imem_req && gnt) begin
      chk("single_outstanding", pend_v, 32'd0);
      pend_v    = 1'b1;
      pend_due  = cyc_n + lat;
      pend_data = mem_word(imem_addr);
    end
    if (!redir && id_valid && !stall && !misal) begin
      w = mem_word(exp_pc);
      chk("sb_pc", id_pc, exp_pc);
      chk("sb_instr", id_instr, w);
      chk("sb_pc4", id_pc4, exp_pc + 32'd4);
      chk("sb_fields", {id_f7, id_f3, id_opcode}, {w[31:25], w[14:12], w[6:0]});
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    if (redir) exp_pc = rpc;
`else
    if (redir) exp_pc = rpc & 32'hFFFF_FFFC;
`endif
    prev_req   = imem_req;
    prev_gnt   = gnt;
    prev_redir = redir;
    prev_valid = id_valid;
    prev_stall = stall;
    prev_addr  = imem_addr;
    prev_instr = id_instr;
    prev_pc    = id_pc;
    prev_pc4   = id_pc4;
    @(negedge clk);
    cyc_n++;
  endtask

  initial begin
    int          vcnt;
    logic [31:0] x;
    logic        found;
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0800;  // rst must win
    @(negedge clk);
    chk("rst_valid", id_valid, 32'd0);
    chk("rst_instr", id_instr, NOP);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc4", id_pc4, 32'h4);
    redirect_valid = 1'b0;
    #1 chk("rst_req", imem_req, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc_n = 1;

    // zero-wait memory
    lat = 1;
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("boot_no_req", last_req, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("first_req", last_req, 32'd1);
    chk("first_addr", last_addr, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("first_valid", id_valid, 32'd1);
    chk("first_pc", id_pc, 32'h0);
    chk("first_opcode", id_opcode, 32'h13);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("second_pc", id_pc, 32'h4);
    chk("second_instr", id_instr, 32'h0010_0113);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      if (id_valid) vcnt++;
    end
    chk("throughput", vcnt, 32'd8);

    // decode stall for 3 cycles mid-stream
    x = id_pc;
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall_resp_arrives", last_rvalid, 32'd1);
    chk("stall_no_req1", last_req, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall_no_req2", last_req, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall_no_req3", last_req, 32'd0);
    chk("stall_hold_pc", id_pc, x);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("skid_out_pc", id_pc, x + 32'd4);
    chk("skid_full_no_req", last_req, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("post_skid_req", last_req, 32'd1);
    chk("post_skid_addr", last_addr, x + 32'd8);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // redirect while waiting, response two cycles later
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      if (last_req) begin found = 1'b1; break; end
    end
    chk("slow_grant_seen", found, 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    chk("redir_clear_valid", id_valid, 32'd0);
    chk("redir_clear_instr", id_instr, NOP);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("drain_no_req", last_req, 32'd0);
    lat = 1;
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("drain_rvalid", last_rvalid, 32'd1);
    chk("drain_no_req2", last_req, 32'd0);
    chk("drain_discard", id_valid, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_req", last_req, 32'd1);
    chk("redir_addr", last_addr, 32'h0000_0100);
    for (int i = 0; i < 10 && !id_valid; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_first_valid", id_valid, 32'd1);
    chk("redir_first_pc", id_pc, 32'h0000_0100);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // redirect coinciding with rvalid while stalled
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0300);
    chk("redir_rv_seen", last_rvalid, 32'd1);
    chk("redir_rv_valid", id_valid, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_rv_req", last_req, 32'd1);
    chk("redir_rv_addr", last_addr, 32'h0000_0300);
    repeat (6) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // redirect with the skid buffer full
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0400);
    chk("redir_skid_valid", id_valid, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_skid_addr", last_addr, 32'h0000_0400);
    for (int i = 0; i < 10 && !id_valid; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_skid_pc", id_pc, 32'h0000_0400);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // grant withheld for 4 cycles
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    x = last_addr;
    chk("nognt_req0", last_req, 32'd1);
    for (int i = 1; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      chk("nognt_req", last_req, 32'd1);
      chk("nognt_addr", last_addr, x);
    end
    chk("nognt_empty", id_valid, 32'd0);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // PC wrap
    cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      if (id_valid && id_pc == 32'hFFFF_FFFC) begin found = 1'b1; break; end
    end
    chk("wrap_seen", found, 32'd1);
    chk("wrap_pc4", id_pc4, 32'h0);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0102);
    chk("mis_flag", id_misalign, 32'd1);
    chk("mis_valid", id_valid, 32'd1);
    chk("mis_pc", id_pc, 32'h0000_0102);
    chk("mis_instr", id_instr, NOP);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      chk("mis_no_req", last_req, 32'd0);
    end
    chk("mis_flag_held", id_misalign, 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0200);
    chk("mis_flag_clr", id_misalign, 32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      if (last_req) break;
    end
    chk("mis_resume_req", last_req, 32'd1);
    chk("mis_resume_addr", last_addr, 32'h0000_0200);
`else
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0502);
    for (int i = 0; i < 10 && !id_valid; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("lowbits_ignored", id_pc, 32'h0000_0500);
`endif
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 3);
      cyc(($urandom_range(0, 9) < 6), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 32) == 0), ($urandom & 32'hFFFF_FFFC));
    end
    lat = 1;
    repeat (20) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("progress", (consumed > 150), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
